lsu_stage: RTL

- Load/store unit between the execute stage and m_stage in the in-order RV64 core.
- Accepts one execute-stage result per handshake. Non-memory instructions pass through with one registered cycle.
- Loads and stores are sent to the data-memory bus through a req/gnt/rvalid handshake. Load data is aligned and sign- or zero-extended.
- Registered results (data, w_ena, w_addr, inst_type) go to m_stage.

---
 rtl/lsu_stage_pkg.sv | 44 ++++
 rtl/lsu_align.sv | 48 ++++
 rtl/lsu_stage.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/lsu_stage_pkg.sv
// Shared types and constants for the load/store stage.
package lsu_stage_pkg;

  localparam int XLEN    = 64;
  localparam int REG_BUS = XLEN;
  localparam logic [REG_BUS-1:0] ZERO_WORD = '0;

  localparam logic [4:0] INST_ALU   = 5'b10000;
  localparam logic [4:0] INST_LOAD  = 5'b01000;
  localparam logic [4:0] INST_STORE = 5'b00100;

  localparam logic [2:0] F3_B   = 3'b000;
  localparam logic [2:0] F3_H   = 3'b001;
  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_D   = 3'b011;
  localparam logic [2:0] F3_BU  = 3'b100;
  localparam logic [2:0] F3_HU  = 3'b101;
  localparam logic [2:0] F3_WU  = 3'b110;
  localparam logic [2:0] F3_BAD = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } lsu_state_e;

  // funct3[1:0] is the access size; the reserved encoding is reported as misaligned.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [2:0] offset);
    logic mis;
    if (funct3 == F3_BAD) begin
      mis = 1'b1;
    end else begin
      case (funct3[1:0])
        2'b00:   mis = 1'b0;
        2'b01:   mis = offset[0];
        2'b10:   mis = |offset[1:0];
        default: mis = |offset;
      endcase
    end
    return mis;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane placement for stores and extract/extend for loads; purely combinational.
module lsu_align
  import lsu_stage_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [2:0]      offset,
  input  logic [XLEN-1:0] store_data,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] wdata,
  output logic [7:0]      wmask,
  output logic [XLEN-1:0] load_data
);

  logic [5:0]      shamt;
  logic [XLEN-1:0] shifted;

  assign shamt   = {offset, 3'b000};
  assign shifted = rdata >> shamt;

  always_comb begin
    wdata = store_data << shamt;
    wmask = 8'h00;
    case (funct3[1:0])
      2'b00: begin
        wmask = 8'h01 << offset;
        wdata = {8{store_data[7:0]}};
      end
      2'b01:   wmask = 8'h03 << offset;
      2'b10:   wmask = 8'h0F << offset;
      default: wmask = 8'hFF;
    endcase
  end

  always_comb begin
    load_data = ZERO_WORD;
    case (funct3)
      F3_B:    load_data = {{56{shifted[7]}}, shifted[7:0]};
      F3_H:    load_data = {{48{shifted[15]}}, shifted[15:0]};
      F3_W:    load_data = {{32{shifted[31]}}, shifted[31:0]};
      F3_D:    load_data = shifted;
      F3_BU:   load_data = {56'd0, shifted[7:0]};
      F3_HU:   load_data = {48'd0, shifted[15:0]};
      F3_WU:   load_data = {32'd0, shifted[31:0]};
      default: load_data = ZERO_WORD;
    endcase
  end

endmodule

// File: rtl/lsu_stage.sv
// Load/store stage between execute and m_stage: single-outstanding data-memory access
// over a req/gnt/rvalid bus, with a one-entry registered output toward m_stage.
//
// state | meaning
// IDLE  | ready for a new instruction when the output register is free
// REQ   | dmem_req asserted, bus fields held until gnt
// WAIT  | granted, waiting for rvalid
// DONE  | result captured, waiting for the output register to drain
module lsu_stage
  import lsu_stage_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [4:0]      ex_inst_type,
  input  logic [2:0]      ex_funct3,
  input  logic [XLEN-1:0] ex_result,
  input  logic [XLEN-1:0] ex_store_data,
  input  logic            ex_w_ena,
  input  logic [4:0]      ex_w_addr,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [7:0]      dmem_wmask,
  input  logic            dmem_gnt,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [4:0]      m_inst_type,
  output logic [XLEN-1:0] m_data,
  output logic            m_w_ena,
  output logic [4:0]      m_w_addr,
  output logic            m_misalign
);

  lsu_state_e state_q, state_d;

  logic [XLEN-1:0] addr_q;
  logic [2:0]      funct3_q;
  logic            is_load_q;
  logic            w_ena_q;
  logic [4:0]      w_addr_q;
  logic [4:0]      type_q;
  logic [XLEN-1:0] res_q;
  logic            res_w_ena_q;

  logic            out_free, accept, is_mem, ex_mis;
  logic            out_load, start_bus, hold_res, bus_done;
  logic [XLEN-1:0] out_data;
  logic            out_w_ena, out_mis;
  logic [4:0]      out_w_addr, out_type;
  logic [XLEN-1:0] mem_result;
  logic            mem_w_ena;

  logic [2:0]      al_funct3, al_offset;
  logic [XLEN-1:0] al_wdata, al_load;
  logic [7:0]      al_wmask;

  assign out_free = !m_valid || m_ready;
  assign ex_ready = (state_q == S_IDLE) && out_free;
  assign accept   = ex_valid && ex_ready;
  assign is_mem   = (ex_inst_type == INST_LOAD) || (ex_inst_type == INST_STORE);
  assign ex_mis   = is_misaligned(ex_funct3, ex_result[2:0]);

  // One align unit: store lanes are formed at accept, load extract once the access is in flight.
  assign al_funct3 = (state_q == S_IDLE) ? ex_funct3 : funct3_q;
  assign al_offset = (state_q == S_IDLE) ? ex_result[2:0] : addr_q[2:0];

  lsu_align u_align (
    .funct3     (al_funct3),
    .offset     (al_offset),
    .store_data (ex_store_data),
    .rdata      (dmem_rdata),
    .wdata      (al_wdata),
    .wmask      (al_wmask),
    .load_data  (al_load)
  );

  assign mem_result = is_load_q ? al_load : addr_q;
  assign mem_w_ena  = is_load_q && w_ena_q;

  always_comb begin
    state_d    = state_q;
    out_load   = 1'b0;
    start_bus  = 1'b0;
    hold_res   = 1'b0;
    bus_done   = 1'b0;
    out_data   = ZERO_WORD;
    out_w_ena  = 1'b0;
    out_mis    = 1'b0;
    out_w_addr = w_addr_q;
    out_type   = type_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (is_mem && !ex_mis) begin
            start_bus = 1'b1;
            state_d   = S_REQ;
          end else begin
            out_load   = 1'b1;
            out_data   = ex_result;
            out_w_ena  = ex_w_ena && !is_mem;
            out_mis    = is_mem;
            out_w_addr = ex_w_addr;
            out_type   = ex_inst_type;
          end
        end
      end
      S_REQ: begin
        if (dmem_gnt) begin
          if (dmem_rvalid) bus_done = 1'b1;
          else             state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (dmem_rvalid) bus_done = 1'b1;
      end
      S_DONE: begin
        if (out_free) begin
          out_load  = 1'b1;
          out_data  = res_q;
          out_w_ena = res_w_ena_q;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (bus_done) begin
      if (out_free) begin
        out_load  = 1'b1;
        out_data  = mem_result;
        out_w_ena = mem_w_ena;
        state_d   = S_IDLE;
      end else begin
        hold_res = 1'b1;
        state_d  = S_DONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      dmem_addr   <= ZERO_WORD;
      dmem_wdata  <= ZERO_WORD;
      dmem_wmask  <= 8'h00;
      m_valid     <= 1'b0;
      m_data      <= ZERO_WORD;
      m_w_ena     <= 1'b0;
      m_w_addr    <= 5'd0;
      m_inst_type <= 5'd0;
      m_misalign  <= 1'b0;
      addr_q      <= ZERO_WORD;
      funct3_q    <= 3'd0;
      is_load_q   <= 1'b0;
      w_ena_q     <= 1'b0;
      w_addr_q    <= 5'd0;
      type_q      <= 5'd0;
      res_q       <= ZERO_WORD;
      res_w_ena_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (m_valid && m_ready) m_valid <= 1'b0;
      if (out_load) begin
        m_valid     <= 1'b1;
        m_data      <= out_data;
        m_w_ena     <= out_w_ena;
        m_w_addr    <= out_w_addr;
        m_inst_type <= out_type;
        m_misalign  <= out_mis;
      end
      if (start_bus) begin
        addr_q     <= ex_result;
        funct3_q   <= ex_funct3;
        is_load_q  <= (ex_inst_type == INST_LOAD);
        w_ena_q    <= ex_w_ena;
        w_addr_q   <= ex_w_addr;
        type_q     <= ex_inst_type;
        dmem_req   <= 1'b1;
        dmem_we    <= (ex_inst_type == INST_STORE);
        dmem_addr  <= {ex_result[XLEN-1:3], 3'b000};
        dmem_wdata <= (ex_inst_type == INST_STORE) ? al_wdata : ZERO_WORD;
        dmem_wmask <= (ex_inst_type == INST_STORE) ? al_wmask : 8'h00;
      end
      if (state_q == S_REQ && dmem_gnt) dmem_req <= 1'b0;
      if (hold_res) begin
        res_q       <= mem_result;
        res_w_ena_q <= mem_w_ena;
      end
    end
  end

endmodule
